// File: rtl/vga_mux_pkg.sv
// rtl/vga_mux_pkg.sv - shared state type, field indices and defaults for vga_field_mux
package vga_mux_pkg;

  typedef enum logic [1:0] {
    SHOW,
    EDIT_CLK,
    EDIT_TMR,
    WAIT_RD
  } mux_state_e;

  localparam int F_SEG    = 0;
  localparam int F_MIN    = 1;
  localparam int F_HORA   = 2;
  localparam int F_DIA    = 3;
  localparam int F_MES    = 4;
  localparam int F_ANO    = 5;
  localparam int F_SEG_T  = 6;
  localparam int F_MIN_T  = 7;
  localparam int F_HORA_T = 8;

  localparam int CLK_FIELDS_DEF = 6;

endpackage

// File: rtl/vga_field_mux_blink.sv
// rtl/vga_field_mux_blink.sv - blink phase generator; phase toggles every DIV cycles
module blink_gen #(
  parameter int DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic phase
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vga_field_mux.sv
// rtl/vga_field_mux.sv - registered per-group selector between user edits and latched RTC data
// Optional cursor blinking is compiled in with VGA_MUX_BLINK_EN.
module vga_field_mux
  import vga_mux_pkg::*;
#(
  parameter int FIELD_W    = 8,
  parameter int N_FIELDS   = 9,
  parameter int CLK_FIELDS = CLK_FIELDS_DEF,
  parameter int BLINK_DIV  = 12_500_000,
  parameter int WAIT_MAX   = 50_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en_escr,
  input  logic                         en_clock,
  input  logic [N_FIELDS*FIELD_W-1:0]  usu_data,
  input  logic [N_FIELDS*FIELD_W-1:0]  rtc_data,
  input  logic                         rtc_valid,
  input  logic [$clog2(N_FIELDS)-1:0]  cursor,
  output logic [N_FIELDS*FIELD_W-1:0]  vga_data,
  output logic                         vga_update,
  output logic [N_FIELDS-1:0]          blank_mask
);

  localparam int DATA_W = N_FIELDS * FIELD_W;
  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  mux_state_e        state, state_nxt;
  logic [DATA_W-1:0] rtc_shadow, vga_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;

  assign timeout = (wait_cnt == WAIT_W'(WAIT_MAX - 1));

  always_comb begin
    state_nxt = state;
    if (en_escr) begin
      state_nxt = en_clock ? EDIT_CLK : EDIT_TMR;
    end else begin
      case (state)
        EDIT_CLK, EDIT_TMR: state_nxt = WAIT_RD;
        WAIT_RD:            if (rtc_valid || timeout) state_nxt = SHOW;
        default:            state_nxt = state;
      endcase
    end
  end

  // WAIT_RD freezes the frame; otherwise each field picks user or shadowed RTC data.
  always_comb begin
    vga_nxt = vga_data;
    if (state != WAIT_RD) begin
      for (int i = 0; i < N_FIELDS; i++) begin
        if ((state == EDIT_CLK && i < CLK_FIELDS) || (state == EDIT_TMR && i >= CLK_FIELDS))
          vga_nxt[i*FIELD_W +: FIELD_W] = usu_data[i*FIELD_W +: FIELD_W];
        else
          vga_nxt[i*FIELD_W +: FIELD_W] = rtc_shadow[i*FIELD_W +: FIELD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SHOW;
      rtc_shadow <= '0;
      vga_data   <= '0;
      vga_update <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      if (rtc_valid) rtc_shadow <= rtc_data;
      vga_data   <= vga_nxt;
      vga_update <= (vga_nxt != vga_data);
      wait_cnt   <= (state == WAIT_RD) ? wait_cnt + WAIT_W'(1) : '0;
    end
  end

`ifdef VGA_MUX_BLINK_EN
  logic [$clog2(N_FIELDS)-1:0] cursor_q;
  logic                        blink_clr, phase, in_group, edit_nxt;

  assign edit_nxt  = (state_nxt == EDIT_CLK) || (state_nxt == EDIT_TMR);
  assign blink_clr = (edit_nxt && state_nxt != state) || (cursor != cursor_q);

  blink_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk   (clk),
    .reset (reset),
    .clr   (blink_clr),
    .phase (phase)
  );

  always_ff @(posedge clk) begin
    if (reset) cursor_q <= '0;
    else       cursor_q <= cursor;
  end

  // A freshly moved cursor is held visible until the phase restart lands.
  always_comb begin
    blank_mask = '0;
    in_group   = (state == EDIT_CLK && int'(cursor) < CLK_FIELDS) ||
                 (state == EDIT_TMR && int'(cursor) >= CLK_FIELDS && int'(cursor) < N_FIELDS);
    if (in_group && phase && cursor == cursor_q) blank_mask[cursor] = 1'b1;
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^cursor;
  assign blank_mask    = '0;
`endif

endmodule

// File: tb/tb_vga_field_mux.sv
// tb/tb_vga_field_mux.sv - randomized scoreboard bench for vga_field_mux
module tb_vga_field_mux;
  import vga_mux_pkg::*;

  localparam int FW = 8;
  localparam int NF = 9;
  localparam int CF = 6;
  localparam int BD = 4;
  localparam int WM = 16;

  logic             clk = 1'b0;
  logic             reset, en_escr, en_clock, rtc_valid;
  logic [NF*FW-1:0] usu_data, rtc_data, vga_data;
  logic [3:0]       cursor;
  logic             vga_update;
  logic [NF-1:0]    blank_mask;

  always #5 clk = ~clk;

  vga_field_mux #(
    .FIELD_W(FW), .N_FIELDS(NF), .CLK_FIELDS(CF), .BLINK_DIV(BD), .WAIT_MAX(WM)
  ) dut (
    .clk(clk), .reset(reset), .en_escr(en_escr), .en_clock(en_clock),
    .usu_data(usu_data), .rtc_data(rtc_data), .rtc_valid(rtc_valid), .cursor(cursor),
    .vga_data(vga_data), .vga_update(vga_update), .blank_mask(blank_mask)
  );

  typedef struct {
    logic [NF*FW-1:0] vga;
    logic             upd;
    logic [NF-1:0]    mask;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference: what the screen should show, tracked as a view mode plus timestamps.
  typedef enum {V_RTC, V_USER_CLK, V_USER_TMR, V_HOLD} view_t;
  view_t      view = V_RTC;
  logic [7:0] shadow[NF];
  logic [7:0] shown[NF];
  int         cyc = 0, hold_start = 0, blink_start = 0;
  logic [3:0] prev_cursor = '0;

  function automatic bit user_owns(view_t v, int i);
    return (v == V_USER_CLK && i < CF) || (v == V_USER_TMR && i >= CF);
  endfunction

  task automatic model_step();
    exp_t       e;
    logic [7:0] nxt[NF];
    logic       changed;
    view_t      nv;
    cyc++;
    changed = 1'b0;
    if (reset) begin
      view = V_RTC;
      for (int i = 0; i < NF; i++) begin shadow[i] = 8'h00; shown[i] = 8'h00; end
      prev_cursor = '0;
      blink_start = cyc;
    end else begin
      for (int i = 0; i < NF; i++) begin
        if (view == V_HOLD)        nxt[i] = shown[i];
        else if (user_owns(view, i)) nxt[i] = usu_data[i*FW +: FW];
        else                       nxt[i] = shadow[i];
        if (nxt[i] != shown[i]) changed = 1'b1;
      end
      if (rtc_valid) for (int i = 0; i < NF; i++) shadow[i] = rtc_data[i*FW +: FW];
      nv = view;
      if (en_escr) nv = en_clock ? V_USER_CLK : V_USER_TMR;
      else if (view == V_USER_CLK || view == V_USER_TMR) begin nv = V_HOLD; hold_start = cyc; end
      else if (view == V_HOLD && (rtc_valid || cyc - hold_start == WM)) nv = V_RTC;
      if ((nv == V_USER_CLK || nv == V_USER_TMR) && (nv != view || cursor != prev_cursor))
        blink_start = cyc;
      prev_cursor = cursor;
      view = nv;
      for (int i = 0; i < NF; i++) shown[i] = nxt[i];
    end
    for (int i = 0; i < NF; i++) e.vga[i*FW +: FW] = shown[i];
    e.upd  = changed;
    e.mask = '0;
`ifdef VGA_MUX_BLINK_EN
    if (((view == V_USER_CLK && cursor < CF) || (view == V_USER_TMR && cursor >= CF && cursor < NF))
        && (((cyc - blink_start) / BD) % 2 == 1))
      e.mask[cursor] = 1'b1;
`endif
    sb.push_back(e);
  endtask

  task automatic tick(int n = 1);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(negedge clk);
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit   bad;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        bad = 1'b0;
        if (vga_data !== e.vga) begin
          $display("FAIL vga_data vec %0d: got %h want %h", vectors, vga_data, e.vga);
          bad = 1'b1;
        end
        if (vga_update !== e.upd) begin
          $display("FAIL vga_update vec %0d: got %b want %b", vectors, vga_update, e.upd);
          bad = 1'b1;
        end
        if (blank_mask !== e.mask) begin
          $display("FAIL blank_mask vec %0d: got %h want %h", vectors, blank_mask, e.mask);
          bad = 1'b1;
        end
        if (bad) miscompares++;
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1; en_escr = 1'b0; en_clock = 1'b1; rtc_valid = 1'b0;
    usu_data = '0; rtc_data = '0; cursor = '0;
    @(negedge clk);
    tick(2);
    reset = 1'b0;
    tick(1);

    rtc_data[F_MIN*FW +: FW] = 8'h34; rtc_valid = 1'b1; tick(1);
    rtc_valid = 1'b0; tick(3);

    rtc_data[F_SEG_T*FW +: FW] = 8'h05; rtc_data[F_HORA*FW +: FW] = 8'h09;
    rtc_valid = 1'b1; tick(1);
    rtc_valid = 1'b0;
    usu_data[F_HORA*FW +: FW] = 8'h12; usu_data[F_MIN*FW +: FW] = 8'h45;
    en_escr = 1'b1; en_clock = 1'b1; cursor = 4'd2; tick(12);
    cursor = 4'd7; tick(5);
    cursor = 4'd2; tick(3);

    en_escr = 1'b0; tick(20);

    en_escr = 1'b1; tick(3);
    en_escr = 1'b0; tick(3);
    rtc_data[F_HORA*FW +: FW] = 8'h13; rtc_valid = 1'b1; tick(1);
    rtc_valid = 1'b0; tick(3);

    usu_data[F_SEG_T*FW +: FW] = 8'h27;
    en_escr = 1'b1; en_clock = 1'b1; tick(3);
    en_clock = 1'b0; tick(4);
    cursor = 4'd7; tick(9);
    cursor = 4'd12; tick(3);

    reset = 1'b1; tick(1);
    reset = 1'b0; tick(2);
    en_escr = 1'b0; tick(5);
    reset = 1'b1; tick(1);
    reset = 1'b0; tick(2);

    for (int n = 0; n < 800; n++) begin
      reset     = ($urandom_range(0, 99) == 0);
      rtc_data  = {$urandom, $urandom, $urandom};
      rtc_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 11) == 0) en_escr  = ~en_escr;
      if ($urandom_range(0, 9) == 0)  en_clock = ~en_clock;
      if ($urandom_range(0, 7) == 0)  cursor   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0)
        usu_data[$urandom_range(0, NF-1)*FW +: FW] = 8'($urandom);
      tick(1);
    end

    reset = 1'b0; en_escr = 1'b0; rtc_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
